// File: rtl/input_debounce_conditioner.sv
// Synchronises a raw asynchronous input, then qualifies each level change over
// STABLE_CYCLES identical samples. Emits a clean level, rise/fall strobes and a glitch count.
module input_debounce_conditioner #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned GLITCH_CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_async,
    input  logic                    clear_glitch,
    output logic                    level,
    output logic                    rise,
    output logic                    fall,
    output logic                    busy,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_CHK_H = 2'd1,
        S_HIGH  = 2'd2,
        S_CHK_L = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   a_s;
    logic                   abort;

    // Metastability chain; only the last stage is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_async};
        end
    end

    assign a_s   = sync_q[SYNC_STAGES-1];
    assign busy  = (state == S_CHK_H) || (state == S_CHK_L);
    assign abort = ((state == S_CHK_H) && !a_s) || ((state == S_CHK_L) && a_s);

    // Qualification FSM; strobes default low so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                S_LOW: begin
                    if (a_s) begin
                        if (STABLE_CYCLES == 1) begin
                            state <= S_HIGH;
                            level <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            state <= S_CHK_H;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                S_CHK_H: begin
                    if (!a_s) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!a_s) begin
                        if (STABLE_CYCLES == 1) begin
                            state <= S_LOW;
                            level <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            state <= S_CHK_L;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                S_CHK_L: begin
                    if (a_s) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating abort counter; clear takes priority over a same-cycle abort.
    always_ff @(posedge clk) begin
        if (rst || clear_glitch) begin
            glitch_cnt <= '0;
        end else if (abort && (glitch_cnt != GLITCH_MAX)) begin
            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_input_debounce_conditioner.sv
// Bench for input_debounce_conditioner: a default instance and a fast instance
// (3 sync stages, 1 stable cycle) checked every cycle against a run-length model.
module tb_input_debounce_conditioner;

    localparam int SYNC_D = 2;
    localparam int STAB_D = 4;
    localparam int SYNC_F = 3;
    localparam int STAB_F = 1;
    localparam int GMAX   = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       a0, a1, clr0, clr1;
    logic       level0, rise0, fall0, busy0;
    logic       level1, rise1, fall1, busy1;
    logic [7:0] gc0, gc1;

    always #5 clk = ~clk;

    input_debounce_conditioner u_def (
        .clk(clk), .rst(rst), .a_async(a0), .clear_glitch(clr0),
        .level(level0), .rise(rise0), .fall(fall0), .busy(busy0), .glitch_cnt(gc0)
    );

    input_debounce_conditioner #(
        .SYNC_STAGES(SYNC_F), .STABLE_CYCLES(STAB_F), .GLITCH_CNT_W(8)
    ) u_fast (
        .clk(clk), .rst(rst), .a_async(a1), .clear_glitch(clr1),
        .level(level1), .rise(rise1), .fall(fall1), .busy(busy1), .glitch_cnt(gc1)
    );

    // Drive values applied at each negedge.
    bit rst_d, a0_d, a1_d, clr0_d, clr1_d;

    // Model: a delay line of captured samples, then a run of disagreeing samples
    // flips the level once it reaches the stable count; a broken run is a glitch.
    bit hist0[$];
    bit hist1[$];
    int run_m[2];
    bit lvl_m[2];
    bit rise_m[2];
    bit fall_m[2];
    int gl_m[2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist0 = {};
        hist1 = {};
        for (int i = 0; i < SYNC_D; i++) hist0.push_back(1'b0);
        for (int i = 0; i < SYNC_F; i++) hist1.push_back(1'b0);
        for (int d = 0; d < 2; d++) begin
            run_m[d]  = 0;
            lvl_m[d]  = 1'b0;
            rise_m[d] = 1'b0;
            fall_m[d] = 1'b0;
            gl_m[d]   = 0;
        end
    endtask

    task automatic model_edge(input int d, input int stable_n, input bit a_s, input bit clr);
        rise_m[d] = 1'b0;
        fall_m[d] = 1'b0;
        if (a_s != lvl_m[d]) begin
            run_m[d]++;
            if (run_m[d] >= stable_n) begin
                lvl_m[d]  = a_s;
                rise_m[d] = a_s;
                fall_m[d] = !a_s;
                run_m[d]  = 0;
            end
        end else begin
            if (run_m[d] > 0 && gl_m[d] < GMAX) gl_m[d]++;
            run_m[d] = 0;
        end
        if (clr) gl_m[d] = 0;
    endtask

    task automatic check_all();
        chk("def.level", 32'(level0), 32'(lvl_m[0]));
        chk("def.rise",  32'(rise0),  32'(rise_m[0]));
        chk("def.fall",  32'(fall0),  32'(fall_m[0]));
        chk("def.busy",  32'(busy0),  (run_m[0] != 0) ? 32'd1 : 32'd0);
        chk("def.glitch_cnt", 32'(gc0), 32'(gl_m[0]));
        chk("fast.level", 32'(level1), 32'(lvl_m[1]));
        chk("fast.rise",  32'(rise1),  32'(rise_m[1]));
        chk("fast.fall",  32'(fall1),  32'(fall_m[1]));
        chk("fast.busy",  32'(busy1),  (run_m[1] != 0) ? 32'd1 : 32'd0);
        chk("fast.glitch_cnt", 32'(gc1), 32'(gl_m[1]));
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
    task automatic tick();
        bit s0, s1;
        rst  = rst_d;
        a0   = a0_d;
        a1   = a1_d;
        clr0 = clr0_d;
        clr1 = clr1_d;
        @(posedge clk);
        if (rst_d) begin
            model_reset();
        end else begin
            s0 = hist0.pop_front();
            hist0.push_back(a0_d);
            s1 = hist1.pop_front();
            hist1.push_back(a1_d);
            model_edge(0, STAB_D, s0, clr0_d);
            model_edge(1, STAB_F, s1, clr1_d);
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, rcnt, fcnt, strobes, hold;
        bit found, at_edge, want;

        rst = 1'b1; a0 = 1'b0; a1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        rst_d = 1'b1; a0_d = 1'b0; a1_d = 1'b0; clr0_d = 1'b0; clr1_d = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) tick();
        rst_d = 1'b0;
        repeat (3) tick();

        // Clean rise: level 6 edges after capture, busy for 3 cycles before it.
        a0_d = 1'b1; lat = 0; bcnt = 0; found = 1'b0; at_edge = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (busy0) bcnt++;
            if (level0) begin found = 1'b1; lat = i; at_edge = rise0; end
        end
        chk("t1.rise_latency", 32'(lat), 32'd6);
        chk("t1.busy_cycles", 32'(bcnt), 32'd3);
        chk("t1.rise_with_level", 32'(at_edge), 32'd1);
        tick();
        chk("t1.rise_one_cycle", 32'(rise0), 32'd0);
        repeat (4) tick();

        // Clean fall, no rise strobe anywhere in the window.
        a0_d = 1'b0; lat = 0; rcnt = 0; found = 1'b0; at_edge = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            rcnt += int'(rise0);
            if (!level0) begin found = 1'b1; lat = i; at_edge = fall0; end
        end
        chk("t4.fall_latency", 32'(lat), 32'd6);
        chk("t4.fall_with_level", 32'(at_edge), 32'd1);
        chk("t4.no_rise", 32'(rcnt), 32'd0);
        repeat (4) tick();

        // Two-cycle pulse is rejected and counted.
        rcnt = 0;
        a0_d = 1'b1; tick(); rcnt += int'(rise0); tick(); rcnt += int'(rise0);
        a0_d = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); rcnt += int'(rise0); end
        chk("t2.level_low", 32'(level0), 32'd0);
        chk("t2.no_rise", 32'(rcnt), 32'd0);
        chk("t2.glitch_cnt", 32'(gc0), 32'd1);

        // 300 glitches saturate the counter.
        for (int i = 0; i < 300; i++) begin
            a0_d = 1'b1; tick();
            a0_d = 1'b0; tick();
        end
        repeat (4) tick();
        chk("t3.glitch_saturated", 32'(gc0), 32'd255);
        // Clear on the exact edge an abort occurs: capture, drop, wait, then abort edge.
        a0_d = 1'b1; tick();
        a0_d = 1'b0; tick();
        tick();
        clr0_d = 1'b1; tick();
        clr0_d = 1'b0;
        chk("t3.clear_beats_abort", 32'(gc0), 32'd0);
        repeat (3) tick();

        // Randomised run with mixed hold lengths and sparse clears.
        for (int k = 0; k < 150; k++) begin
            a0_d = 1'($urandom_range(0, 1));
            a1_d = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 8));
            for (int j = 0; j < hold; j++) begin
                clr0_d = ($urandom_range(0, 15) == 0);
                clr1_d = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        clr0_d = 1'b0; clr1_d = 1'b0;

        // Fast instance: toggles every 5 cycles, each edge seen 4 edges after capture.
        a1_d = 1'b0;
        repeat (6) tick();
        for (int e = 0; e < 6; e++) begin
            a1_d = !a1_d; want = a1_d; lat = 0; strobes = 0;
            for (int i = 1; i <= 5; i++) begin
                tick();
                strobes += int'(rise1) + int'(fall1);
                if (lat == 0 && level1 == want) lat = i;
            end
            chk("t5.edge_latency", 32'(lat), 32'd4);
            chk("t5.strobes_per_edge", 32'(strobes), 32'd1);
        end

        // Reset while qualifying a fall, input held high through release.
        a0_d = 1'b1; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (level0) found = 1'b1;
        end
        chk("t6.reached_high", 32'(found), 32'd1);
        repeat (2) tick();
        a0_d = 1'b0;
        repeat (3) tick();
        chk("t6.busy_before_rst", 32'(busy0), 32'd1);
        chk("t6.level_before_rst", 32'(level0), 32'd1);
        rst_d = 1'b1; a0_d = 1'b1; fcnt = 0;
        repeat (2) begin tick(); fcnt += int'(fall0); end
        chk("t6.level_in_rst", 32'(level0), 32'd0);
        chk("t6.no_fall", 32'(fcnt), 32'd0);
        rst_d = 1'b0; lat = 0; found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            fcnt += int'(fall0);
            if (rise0) begin found = 1'b1; lat = i; end
        end
        chk("t6.rise_after_release", 32'(lat), 32'd6);
        chk("t6.no_fall_total", 32'(fcnt), 32'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
